// File: rtl/trap_arbiter.sv
// trap_arbiter: picks the oldest excepting commit lane or the best pending
// interrupt, holds it on a valid/ready handshake, then pulses a pipeline flush.
module trap_arbiter #(
  parameter int              NCOMMIT   = 4,
  parameter int              NIRQ      = 16,
  parameter logic [NIRQ-1:0] EDGE_MASK = '0,
  parameter int              XLEN      = 64,
  parameter int              ROB_SIZE  = 64,
  parameter int              ROBW      = $clog2(ROB_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCOMMIT-1:0]      i_commit_vld,
  input  logic [NCOMMIT-1:0]      i_commit_except,
  input  logic [NCOMMIT*6-1:0]    i_commit_ecause,
  input  logic [NCOMMIT*XLEN-1:0] i_commit_tval,
  input  logic [NCOMMIT*ROBW-1:0] i_commit_robidx,
  input  logic [ROBW-1:0]         i_head_robidx,
  input  logic [NIRQ-1:0]         i_irq,
  input  logic [NIRQ-1:0]         i_irq_clear,
  input  logic [NIRQ-1:0]         i_mie,
  input  logic [NIRQ-1:0]         i_mideleg,
  input  logic [63:0]             i_medeleg,
  input  logic [1:0]              i_priv,
  input  logic                    i_mstatus_mie,
  input  logic                    i_mstatus_sie,
  output logic [NIRQ-1:0]         o_mip,
  output logic                    o_trap_vld,
  input  logic                    i_trap_rdy,
  output logic                    o_trap_is_irq,
  output logic [5:0]              o_trap_cause,
  output logic                    o_trap_to_s,
  output logic [XLEN-1:0]         o_trap_tval,
  output logic [ROBW-1:0]         o_trap_robidx,
  output logic                    o_flush
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Fixed architectural interrupt order, lowest priority first; later entries override.
  localparam logic [5:0] IRQ_PRIO [6] = '{6'd5, 6'd1, 6'd9, 6'd7, 6'd3, 6'd11};

  state_e            state_q, state_d;
  logic [NIRQ-1:0]   irq_q, pend_q, pend_d;
  logic [NIRQ-1:0]   mip_s, take_s, acc_clr_s;
  logic              is_irq_q, is_irq_d, to_s_q, to_s_d;
  logic [5:0]        cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [ROBW-1:0]   robidx_q, robidx_d;

  logic              exc_hit_s, exc_to_s_s;
  logic [5:0]        exc_cause_s;
  logic [XLEN-1:0]   exc_tval_s;
  logic [ROBW-1:0]   exc_rob_s;
  logic              irq_hit_s, irq_to_s_s, m_ok_s, s_ok_s;
  logic [5:0]        irq_cause_s;
  logic              load_s, accept_s;

  assign mip_s    = (irq_q & ~EDGE_MASK) | pend_q;
  assign o_mip    = mip_s;
  assign load_s   = (state_q == ST_IDLE) && (exc_hit_s || irq_hit_s);
  assign accept_s = (state_q == ST_HOLD) && i_trap_rdy;

  // Oldest excepting lane: scan from youngest so the lowest index overrides.
  always_comb begin
    exc_hit_s   = 1'b0;
    exc_cause_s = 6'd0;
    exc_tval_s  = '0;
    exc_rob_s   = '0;
    for (int l = NCOMMIT - 1; l >= 0; l--) begin
      if (i_commit_vld[l] && i_commit_except[l]) begin
        exc_hit_s   = 1'b1;
        exc_cause_s = i_commit_ecause[l*6 +: 6];
        exc_tval_s  = i_commit_tval[l*XLEN +: XLEN];
        exc_rob_s   = i_commit_robidx[l*ROBW +: ROBW];
      end else begin
        exc_hit_s = exc_hit_s;
      end
    end
    exc_to_s_s = i_medeleg[exc_cause_s] && (i_priv != 2'd3);
  end

  // Takeable interrupts and their priority resolution.
  always_comb begin
    m_ok_s      = (i_priv != 2'd3) || i_mstatus_mie;
    s_ok_s      = (i_priv == 2'd0) || ((i_priv == 2'd1) && i_mstatus_sie);
    take_s      = mip_s & i_mie & ((~i_mideleg & {NIRQ{m_ok_s}}) | (i_mideleg & {NIRQ{s_ok_s}}));
    irq_hit_s   = |take_s;
    irq_cause_s = 6'd0;
    irq_to_s_s  = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      irq_cause_s = take_s[i] ? 6'(i) : irq_cause_s;
    end
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NIRQ; i++) begin
        irq_cause_s = (take_s[i] && (6'(i) == IRQ_PRIO[j])) ? 6'(i) : irq_cause_s;
      end
    end
    for (int i = 0; i < NIRQ; i++) begin
      irq_to_s_s = (6'(i) == irq_cause_s) ? i_mideleg[i] : irq_to_s_s;
    end
  end

  // Edge-pending bits: set on a rising line, cleared by CSR or by accepting that interrupt.
  always_comb begin
    for (int i = 0; i < NIRQ; i++) begin
      acc_clr_s[i] = accept_s && is_irq_q && (cause_q == 6'(i));
    end
    pend_d = ((pend_q & ~(i_irq_clear | acc_clr_s)) | (i_irq & ~irq_q)) & EDGE_MASK;
  end

  // Trap field capture on selection; frozen otherwise.
  always_comb begin
    if (load_s) begin
      if (exc_hit_s) begin
        is_irq_d = 1'b0;
        cause_d  = exc_cause_s;
        to_s_d   = exc_to_s_s;
        tval_d   = exc_tval_s;
        robidx_d = exc_rob_s;
      end else begin
        is_irq_d = 1'b1;
        cause_d  = irq_cause_s;
        to_s_d   = irq_to_s_s;
        tval_d   = '0;
        robidx_d = i_head_robidx;
      end
    end else begin
      is_irq_d = is_irq_q;
      cause_d  = cause_q;
      to_s_d   = to_s_q;
      tval_d   = tval_q;
      robidx_d = robidx_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = (exc_hit_s || irq_hit_s) ? ST_HOLD : ST_IDLE;
      ST_HOLD:  state_d = i_trap_rdy ? ST_FLUSH : ST_HOLD;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and flush outputs decoded from the registered state.
  always_comb begin
    o_trap_vld = 1'b0;
    o_flush    = 1'b0;
    case (state_q)
      ST_HOLD:  o_trap_vld = 1'b1;
      ST_FLUSH: o_flush    = 1'b1;
      default: begin
        o_trap_vld = 1'b0;
        o_flush    = 1'b0;
      end
    endcase
  end

  // State, interrupt sampling and trap field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      irq_q    <= '0;
      pend_q   <= '0;
      is_irq_q <= 1'b0;
      cause_q  <= 6'd0;
      to_s_q   <= 1'b0;
      tval_q   <= '0;
      robidx_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= i_irq;
      pend_q   <= pend_d;
      is_irq_q <= is_irq_d;
      cause_q  <= cause_d;
      to_s_q   <= to_s_d;
      tval_q   <= tval_d;
      robidx_q <= robidx_d;
    end
  end

  assign o_trap_is_irq = is_irq_q;
  assign o_trap_cause  = cause_q;
  assign o_trap_to_s   = to_s_q;
  assign o_trap_tval   = tval_q;
  assign o_trap_robidx = robidx_q;

endmodule
